// File: rtl/serial_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_frame_ctrl_pkg
//   Shared definitions for the serial frame controller and its consumers.
//   The MITM decision logic imports this package so that it decodes the
//   controller state and word_idx width consistently.
//   Contents:
//     ST_*        3-bit state encodings
//     state_t     controller state type built on those encodings
//     cnt_width() width of word_idx/word_count for a given MAX_WORDS
// -----------------------------------------------------------------------------
package serial_frame_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_FULL  = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        ARM   = ST_ARM,
        WAIT  = ST_WAIT,
        FULL  = ST_FULL,
        ABORT = ST_ABORT
    } state_t;

    // word_count must be able to hold MAX_WORDS itself, hence the +1.
    function automatic int cnt_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/serial_frame_ctrl.sv
// -----------------------------------------------------------------------------
// serial_frame_ctrl
//   Sequences an external serial read buffer to capture chip-select-framed
//   multi-word transfers. Re-arms the buffer once per word, forwards each
//   completed word with its index, and closes (frame_done) or aborts
//   (frame_aborted + buf_rst pulse) the frame when cs_n is released.
//
//   Ports:
//     sys_clk, rst      clock; asynchronous active-high reset
//     cs_n              chip select (active-low, already synchronized)
//     buf_busy          buffer is shifting bits
//     buf_data_ready    buffer holds a completed word (cleared on start)
//     buf_data          buffer parallel word
//     buf_start         one-cycle start pulse to the buffer
//     buf_rst           buffer reset: rst, or one-cycle pulse on abort
//     word_out/word_idx captured word and its position in the frame
//     word_valid        one-cycle strobe for word_out/word_idx
//     frame_done        one-cycle pulse on clean frame end
//     frame_aborted     one-cycle pulse when the frame ends mid-word
//     word_count        words captured; held after the frame ends
//     overflow          sticky: buffer activity after MAX_WORDS words
//     busy              high from frame start until done/abort
// -----------------------------------------------------------------------------
module serial_frame_ctrl
    import serial_frame_ctrl_pkg::*;
#(
    parameter  int WORD_SIZE = 8,
    parameter  int MAX_WORDS = 4,
    localparam int CNT_W     = cnt_width(MAX_WORDS)
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 buf_busy,
    input  logic                 buf_data_ready,
    input  logic [WORD_SIZE-1:0] buf_data,
    output logic                 buf_start,
    output logic                 buf_rst,
    output logic [WORD_SIZE-1:0] word_out,
    output logic                 word_valid,
    output logic [CNT_W-1:0]     word_idx,
    output logic                 frame_done,
    output logic                 frame_aborted,
    output logic [CNT_W-1:0]     word_count,
    output logic                 overflow,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t               state, state_nxt;
    logic                 buf_rst_pulse, buf_rst_pulse_nxt;
    logic                 buf_start_nxt;
    logic [WORD_SIZE-1:0] word_out_nxt;
    logic                 word_valid_nxt;
    logic [CNT_W-1:0]     word_idx_nxt;
    logic                 frame_done_nxt;
    logic                 frame_aborted_nxt;
    logic [CNT_W-1:0]     word_count_nxt;
    logic [CNT_W-1:0]     count_inc;
    logic                 overflow_nxt;
    logic                 busy_nxt;

    // The buffer must be reset together with this block, so the rst term
    // bypasses the register.
    assign buf_rst   = rst | buf_rst_pulse;
    assign count_inc = word_count + CNT_W'(1);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        buf_start_nxt     = 1'b0;
        buf_rst_pulse_nxt = 1'b0;
        word_out_nxt      = word_out;
        word_valid_nxt    = 1'b0;
        word_idx_nxt      = word_idx;
        frame_done_nxt    = 1'b0;
        frame_aborted_nxt = 1'b0;
        word_count_nxt    = word_count;
        overflow_nxt      = overflow;
        busy_nxt          = busy;

        case (state)
            IDLE: begin
                if (!cs_n) begin
                    word_count_nxt = '0;
                    overflow_nxt   = 1'b0;
                    busy_nxt       = 1'b1;
                    state_nxt      = ARM;
                end
            end

            ARM: begin
                if (cs_n) begin
                    // An empty frame closes silently.
                    frame_done_nxt = (word_count != '0);
                    busy_nxt       = 1'b0;
                    state_nxt      = IDLE;
                end else if (!buf_busy) begin
                    buf_start_nxt = 1'b1;
                    state_nxt     = WAIT;
                end
            end

            WAIT: begin
                if (buf_start) begin
                    // Start pulse is on the wire this cycle; data_ready may
                    // still be stale from the previous word, so ignore it.
                    state_nxt = WAIT;
                end else if (buf_data_ready) begin
                    // Accept even with cs_n high; ARM/FULL handles frame end.
                    word_out_nxt   = buf_data;
                    word_idx_nxt   = word_count;
                    word_valid_nxt = 1'b1;
                    word_count_nxt = count_inc;
                    state_nxt      = (count_inc == MAX_CNT) ? FULL : ARM;
                end else if (cs_n) begin
                    state_nxt = ABORT;
                end
            end

            ABORT: begin
                buf_rst_pulse_nxt = 1'b1;
                frame_aborted_nxt = 1'b1;
                busy_nxt          = 1'b0;
                state_nxt         = IDLE;
            end

            FULL: begin
                if (cs_n) begin
                    frame_done_nxt = 1'b1;
                    busy_nxt       = 1'b0;
                    state_nxt      = IDLE;
                end else if (buf_busy) begin
                    overflow_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            buf_start     <= 1'b0;
            buf_rst_pulse <= 1'b0;
            word_out      <= '0;
            word_valid    <= 1'b0;
            word_idx      <= '0;
            frame_done    <= 1'b0;
            frame_aborted <= 1'b0;
            word_count    <= '0;
            overflow      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            buf_start     <= buf_start_nxt;
            buf_rst_pulse <= buf_rst_pulse_nxt;
            word_out      <= word_out_nxt;
            word_valid    <= word_valid_nxt;
            word_idx      <= word_idx_nxt;
            frame_done    <= frame_done_nxt;
            frame_aborted <= frame_aborted_nxt;
            word_count    <= word_count_nxt;
            overflow      <= overflow_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_ctrl
//   Self-checking bench for serial_frame_ctrl. The serial read buffer is
//   emulated by the stimulus tasks (reacting to buf_start / buf_rst). Expected
//   words are pushed to exp_q as the buffer presents them; a monitor collects
//   word_valid strobes into got_q, and each test drains and compares them.
// -----------------------------------------------------------------------------
module tb_serial_frame_ctrl;

    localparam int WORD_SIZE = 8;
    localparam int MAX_WORDS = 4;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int ENT_W     = CNT_W + WORD_SIZE;

    logic                 sys_clk = 1'b0;
    logic                 rst;
    logic                 cs_n;
    logic                 buf_busy;
    logic                 buf_data_ready;
    logic [WORD_SIZE-1:0] buf_data;
    logic                 buf_start;
    logic                 buf_rst;
    logic [WORD_SIZE-1:0] word_out;
    logic                 word_valid;
    logic [CNT_W-1:0]     word_idx;
    logic                 frame_done;
    logic                 frame_aborted;
    logic [CNT_W-1:0]     word_count;
    logic                 overflow;
    logic                 busy;

    int vectors     = 0;
    int miscompares = 0;

    // Monitor-owned event counters (read-only for the tests).
    int n_done   = 0;
    int n_abort  = 0;
    int n_bufrst = 0;
    int n_start  = 0;

    logic [ENT_W-1:0] exp_q[$];
    logic [ENT_W-1:0] got_q[$];

    serial_frame_ctrl #(
        .WORD_SIZE(WORD_SIZE),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .cs_n          (cs_n),
        .buf_busy      (buf_busy),
        .buf_data_ready(buf_data_ready),
        .buf_data      (buf_data),
        .buf_start     (buf_start),
        .buf_rst       (buf_rst),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .word_idx      (word_idx),
        .frame_done    (frame_done),
        .frame_aborted (frame_aborted),
        .word_count    (word_count),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (!rst) begin
            if (word_valid)    got_q.push_back({word_idx, word_out});
            if (frame_done)    n_done++;
            if (frame_aborted) n_abort++;
            if (buf_rst)       n_bufrst++;
            if (buf_start)     n_start++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next falling edge.
    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (buf_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL start_timeout: buf_start=0 for 20 cycles, required 1");
        end
    endtask

    // Buffer emulation: take a start, shift nbits, then present the word.
    task automatic send_word(input logic [WORD_SIZE-1:0] d, input int nbits,
                             input logic [CNT_W-1:0] idx);
        bit ok;
        wait_start(ok);
        if (!ok) return;
        buf_data_ready = 1'b0;
        buf_busy       = 1'b1;
        repeat (nbits) tick();
        buf_busy       = 1'b0;
        buf_data_ready = 1'b1;
        buf_data       = d;
        exp_q.push_back({idx, d});
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cs_n = 1'b1; buf_busy = 1'b0; buf_data_ready = 1'b0; buf_data = '0;
        repeat (3) tick();
        vectors++;
        if (buf_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_buf_rst: got %b, required 1", buf_rst);
        end
        vectors++;
        if ({word_out, word_idx, word_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_words: got out=%h idx=%0d cnt=%0d, required 0", word_out, word_idx, word_count);
        end
        vectors++;
        if ({buf_start, word_valid, frame_done, frame_aborted, overflow, busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {buf_start, word_valid, frame_done, frame_aborted, overflow, busy});
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({buf_rst, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: got buf_rst=%b busy=%b, required 0 0", buf_rst, busy);
        end
    endtask

    task automatic test_two_words();
        logic [ENT_W-1:0] e, g;
        int d0 = n_done, a0 = n_abort;
        cs_n = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL two_busy: got %b, required 1", busy);
        end
        send_word(8'hA5, 8, CNT_W'(0));
        send_word(8'h3C, 8, CNT_W'(1));
        cs_n = 1'b1;
        tick();
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL two_done_latency: got %b, required 1", frame_done);
        end
        tick();
        vectors++;
        if ({frame_done, busy, word_count} !== {2'b00, CNT_W'(2)} || n_done - d0 != 1 || n_abort != a0) begin
            miscompares++;
            $display("FAIL two_end: got done=%b busy=%b cnt=%0d ndone=%0d nabort=%0d, required 0 0 2 1 0",
                     frame_done, busy, word_count, n_done - d0, n_abort - a0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL two_word: got none, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL two_word: got %h, required %h", g, e);
                end
            end
        end
        vectors++;
        if (got_q.size() != 0) begin
            miscompares++;
            $display("FAIL two_extra: got %0d extra words, required 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_overflow();
        logic [ENT_W-1:0] e, g;
        logic [WORD_SIZE-1:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int d0 = n_done, s0 = n_start;
        cs_n = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send_word(pat[i], 8, CNT_W'(i));
        buf_busy = 1'b1;
        repeat (3) tick();
        buf_busy = 1'b0;
        tick();
        vectors++;
        if ({overflow, word_count} !== {1'b1, CNT_W'(4)} || n_start - s0 != 4) begin
            miscompares++;
            $display("FAIL ovf_full: got ovf=%b cnt=%0d starts=%0d, required 1 4 4",
                     overflow, word_count, n_start - s0);
        end
        cs_n = 1'b1;
        tick();
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_done: got %b, required 1", frame_done);
        end
        tick();
        vectors++;
        if ({busy, overflow, word_count} !== {2'b01, CNT_W'(4)} || n_done - d0 != 1) begin
            miscompares++;
            $display("FAIL ovf_end: got busy=%b ovf=%b cnt=%0d ndone=%0d, required 0 1 4 1",
                     busy, overflow, word_count, n_done - d0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL ovf_word: got none, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL ovf_word: got %h, required %h", g, e);
                end
            end
        end
        vectors++;
        if (got_q.size() != 0) begin
            miscompares++;
            $display("FAIL ovf_extra: got %0d extra words, required 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_abort();
        logic [ENT_W-1:0] e, g;
        bit ok;
        int d0 = n_done, a0 = n_abort, r0 = n_bufrst;
        cs_n = 1'b0;
        tick();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_ovf_clear: got %b, required 0", overflow);
        end
        send_word(8'h5A, 8, CNT_W'(0));
        wait_start(ok);
        buf_data_ready = 1'b0;
        buf_busy       = 1'b1;
        repeat (3) tick();
        cs_n = 1'b1;
        tick();
        vectors++;
        if (frame_aborted !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_early: got %b, required 0", frame_aborted);
        end
        tick();
        vectors++;
        if ({frame_aborted, buf_rst} !== 2'b11) begin
            miscompares++;
            $display("FAIL abort_pulse: got aborted=%b buf_rst=%b, required 1 1", frame_aborted, buf_rst);
        end
        buf_busy = 1'b0;
        tick();
        vectors++;
        if ({frame_aborted, buf_rst, busy, word_count} !== {3'b000, CNT_W'(1)} ||
            n_abort - a0 != 1 || n_bufrst - r0 != 1 || n_done != d0) begin
            miscompares++;
            $display("FAIL abort_end: got ab=%b br=%b busy=%b cnt=%0d nab=%0d nbr=%0d ndone=%0d, required 0 0 0 1 1 1 0",
                     frame_aborted, buf_rst, busy, word_count, n_abort - a0, n_bufrst - r0, n_done - d0);
        end
        cs_n = 1'b0;
        tick();
        send_word(8'hC3, 8, CNT_W'(0));
        cs_n = 1'b1;
        repeat (2) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL abort_word: got none, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL abort_word: got %h, required %h", g, e);
                end
            end
        end
        vectors++;
        if (got_q.size() != 0 || word_count !== CNT_W'(1)) begin
            miscompares++;
            $display("FAIL abort_next: got extra=%0d cnt=%0d, required 0 1", got_q.size(), word_count);
            got_q.delete();
        end
    endtask

    task automatic test_same_cycle();
        logic [ENT_W-1:0] e, g;
        bit ok;
        int d0 = n_done, a0 = n_abort;
        cs_n = 1'b0;
        tick();
        wait_start(ok);
        buf_data_ready = 1'b0;
        buf_busy       = 1'b1;
        repeat (4) tick();
        buf_busy       = 1'b0;
        buf_data_ready = 1'b1;
        buf_data       = 8'h96;
        cs_n           = 1'b1;
        exp_q.push_back({CNT_W'(0), 8'h96});
        tick();
        vectors++;
        if (word_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL same_valid: got %b, required 1", word_valid);
        end
        tick();
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL same_done: got %b, required 1", frame_done);
        end
        tick();
        vectors++;
        if (n_abort != a0 || n_done - d0 != 1 || word_count !== CNT_W'(1)) begin
            miscompares++;
            $display("FAIL same_end: got nab=%0d ndone=%0d cnt=%0d, required 0 1 1",
                     n_abort - a0, n_done - d0, word_count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL same_word: got none, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL same_word: got %h, required %h", g, e);
                end
            end
        end
    endtask

    task automatic test_empty_frame();
        int d0 = n_done, a0 = n_abort, s0 = n_start;
        cs_n = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_busy: got %b, required 1", busy);
        end
        cs_n = 1'b1;
        repeat (3) tick();
        vectors++;
        if (busy !== 1'b0 || word_count !== CNT_W'(0) || n_done != d0 || n_abort != a0 || n_start != s0) begin
            miscompares++;
            $display("FAIL empty_end: got busy=%b cnt=%0d ndone=%0d nab=%0d nstart=%0d, required 0 0 0 0 0",
                     busy, word_count, n_done - d0, n_abort - a0, n_start - s0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [ENT_W-1:0] e, g;
        bit ok;
        cs_n = 1'b0;
        tick();
        wait_start(ok);
        buf_busy = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({buf_rst, busy, buf_start} !== 3'b100) begin
            miscompares++;
            $display("FAIL midrst: got buf_rst=%b busy=%b start=%b, required 1 0 0", buf_rst, busy, buf_start);
        end
        tick();
        rst      = 1'b0;
        cs_n     = 1'b1;
        buf_busy = 1'b0;
        buf_data_ready = 1'b0;
        tick();
        got_q.delete();
        cs_n = 1'b0;
        tick();
        send_word(8'hE7, 8, CNT_W'(0));
        cs_n = 1'b1;
        repeat (2) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL midrst_word: got none, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL midrst_word: got %h, required %h", g, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_overflow();
        test_abort();
        test_same_cycle();
        test_empty_frame();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
